motor_step_gen: RTL and testbench
=================================

// Module: motor_step_gen
// PURPOSE
//  Stepper-motor pulse generator for one axis, directly downstream of fscpu (one instance each for ml/mr/mx/my).
//  Consumes the axis command bundle (start/stop/speed/step/dir/mod_remain/new_remain).
//  Drives the step/dir/enable pins and returns state, position and synchronised zero/terminal sensor flags to fscpu.
// PARAMETERS
//  C_SPEED_DATA_WIDTH   32  width of speed (step period in clk cycles)
//  C_STEP_NUMBER_WIDTH   8  width of step count, remain and position
//  C_FILTER_LEN         16  sensor debounce length in clk cycles (used only with MSG_SENSOR_FILTER_EN)
// PORTS
//  clk            in   1      system clock
//  resetn         in   1      asynchronous, active-low reset
//  sel            in   1      1: fscpu owns this axis; start/stop/mod_remain are ignored when 0
//  start          in   1      one-cycle pulse: begin a move of `step` steps
//  stop           in   1      one-cycle pulse: abort the move
//  speed          in   SDW    step period in clk cycles; values <2 are treated as 2
//  step           in   SNW    steps to move; 0 = no move
//  dir            in   1      1 = positive (toward terminal), 0 = negative (toward zero)
//  mod_remain     in   1      one-cycle pulse: overwrite the remaining-step count
//  new_remain     in   SNW    new remaining-step count
//  zpd            in   1      raw zero-position sensor, async, active-high
//  tpd            in   1      raw terminal-position sensor, async, active-high
//  state          out  1      1 = moving
//  position       out  SNW    step counter, wraps modulo 2^SNW
//  zpsign         out  1      synchronised (optionally filtered) zpd
//  tpsign         out  1      synchronised (optionally filtered) tpd
//  o_drive        out  1      step pulse pin
//  o_dir          out  1      direction pin, latched at start
//  o_xen          out  1      driver enable; equals state
// BEHAVIOUR
//  Reset: state=0, position=0, zpsign=0, tpsign=0, o_drive=0, o_dir=0, o_xen=0; internal counters cleared.
//   Reset mid-move aborts immediately.
//  Sensors: 2-FF synchroniser, so zpsign/tpsign lag zpd/tpd by 2 cycles.
//  FSM states:
//   IDLE -> HIGH: on sel&start&step!=0, unless the sensor in the move direction is already set.
//    A start toward an asserted sensor is rejected and the FSM stays in IDLE.
//    On the accepting edge: latch speed (clamped), dir and remain=step.
//    Next cycle: state=1, o_drive=1, position +/-1 (by dir), remain-1.
//   HIGH -> LOW: after floor(P/2) cycles, where P is the latched period.
//   LOW -> HIGH: after P-floor(P/2) cycles if remain!=0; each HIGH entry counts one step.
//   LOW -> IDLE: at the end of the low phase if remain==0; state=0 the following cycle.
//  Step period is exactly P cycles; a move of N steps lasts N*P cycles from the first o_drive rise to state=0.
//  stop (with sel=1) in HIGH or LOW: o_drive=0 and state=0 next cycle; position keeps all steps already counted.
//  start while moving: ignored.
//  start and stop in the same cycle: stop wins, so no motion results.
//  mod_remain while moving: remain<=new_remain. If 0, the current period completes, then the FSM returns to IDLE.
//   mod_remain in IDLE: ignored.
//  Limits: in HIGH/LOW with dir=0 and zpsign=1: abort as for stop and set position<=0.
//   With dir=1 and tpsign=1: abort as for stop; position is held.
//  position decrementing below 0 wraps to 2^SNW-1.
//  speed, step and dir are sampled only on the accepting start edge; later changes do not affect the move in progress.
// CONFIGURATION
//  MSG_SENSOR_FILTER_EN defined:
//   zpsign/tpsign change only after the synchronised input has held a new value for C_FILTER_LEN consecutive cycles.
//   Total latency is C_FILTER_LEN+2 cycles.
//  MSG_SENSOR_FILTER_EN undefined: no filter; latency 2 cycles; C_FILTER_LEN unused.
// STRUCTURE
//  Shared package motor_pkg:
//   FSM state encoding (IDLE/HIGH/LOW);
//   constant MIN_SPEED=2;
//   direction constants DIR_POS=1 and DIR_NEG=0.
//  Sub-module sensor_sync_filter (2-FF sync plus the optional debounce counter):
//   instantiated twice, for zpd and for tpd;
//   carries the macro-dependent logic.
//  The FSM, period counter, remain counter and position counter stay in the top module.
// TESTING
//  1. speed=10, step=3, dir=1, start at T
//     -> o_drive rises at T+1, T+11, T+21, high 5 cycles each; state=0 at T+31; position=3.
//  2. speed=1, step=2
//     -> period clamped to 2: drive 1,0,1,0; position +2 (a second run gives 4).
//  3. position=3, dir=0, step=10, speed=8; zpd=1 raised mid-move
//     -> state=0 within 3 cycles of zpd; position=0; o_drive=0.
//     Retried start with dir=0 -> rejected, state stays 0.
//  4. speed=4, step=5; stop at step 2
//     -> state=0 next cycle, position=2.
//     start and stop in the same cycle -> no motion.
//  5. speed=6, step=4; mod_remain with new_remain=0 after the first drive rise
//     -> exactly 1 step, state=0 at 6 cycles after that rise.
//     mod_remain with new_remain=7 instead -> 8 steps total.
//  6. Filter on, C_FILTER_LEN=4: tpd glitch of 3 cycles -> tpsign stays 0; 6-cycle pulse -> tpsign=1 at +6.
//     Filter off: any 1-cycle glitch reaches tpsign after 2 cycles.
//     resetn asserted mid-move -> all outputs 0 immediately.

Source files
------------

// File: rtl/motor_pkg.sv
// ============================================================================
//  Module      : motor_pkg
//  Description : Shared constants for the stepper-motor pulse generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package motor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam int MIN_SPEED = 2;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

`default_nettype wire

// File: rtl/motor_step_gen_if.sv
// ============================================================================
//  Module      : motor_step_gen_if
//  Description : Axis command/status bundle between fscpu and motor_step_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motor_step_gen_if #(
  parameter int SDW = 32,
  parameter int SNW = 8
);

  logic           sel;
  logic           start;
  logic           stop;
  logic [SDW-1:0] speed;
  logic [SNW-1:0] step;
  logic           dir;
  logic           mod_remain;
  logic [SNW-1:0] new_remain;
  logic           state;
  logic [SNW-1:0] position;
  logic           zpsign;
  logic           tpsign;

  modport master (
    output sel, start, stop, speed, step, dir, mod_remain, new_remain,
    input  state, position, zpsign, tpsign
  );

  modport slave (
    input  sel, start, stop, speed, step, dir, mod_remain, new_remain,
    output state, position, zpsign, tpsign
  );

endinterface

`default_nettype wire

// File: rtl/sensor_sync_filter.sv
// ============================================================================
//  Module      : sensor_sync_filter
//  Description : 2-FF synchroniser with optional debounce (MSG_SENSOR_FILTER_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_sync_filter #(
  parameter int FILTER_LEN = 16
) (
  input  wire logic clk,
  input  wire logic resetn,
  input  wire logic i_raw,
  output logic      o_sign
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

`ifdef MSG_SENSOR_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sign;

  // Counts consecutive cycles the synchronised level disagrees with the output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_sign <= 1'b0;
    end else if (r_sync == r_sign) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
      r_cnt  <= '0;
      r_sign <= r_sync;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sign = r_sign;
`else
  assign o_sign = r_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/motor_step_gen.sv
// ============================================================================
//  Module      : motor_step_gen
//  Description : One-axis stepper pulse generator; sensor debounce selectable
//                with MSG_SENSOR_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_step_gen
  import motor_pkg::*;
#(
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_STEP_NUMBER_WIDTH = 8,
  parameter int C_FILTER_LEN        = 16
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  motor_step_gen_if.slave bus,
  input  wire logic       zpd,
  input  wire logic       tpd,
  output logic            o_drive,
  output logic            o_dir,
  output logic            o_xen
);

  localparam int SDW = C_SPEED_DATA_WIDTH;
  localparam int SNW = C_STEP_NUMBER_WIDTH;

  logic [1:0]     r_fsm;
  logic [SDW-1:0] r_period;
  logic [SDW-1:0] r_cnt;
  logic [SNW-1:0] r_remain;
  logic [SNW-1:0] r_position;
  logic           r_dir;
  logic           r_drive;

  logic           w_zpsign;
  logic           w_tpsign;
  logic [SDW-1:0] w_speed_clamp;
  logic [SDW-1:0] w_half;
  logic [SDW-1:0] w_low_len;
  logic           w_moving;
  logic           w_blocked;
  logic           w_accept;
  logic           w_zero_hit;
  logic           w_term_hit;
  logic           w_abort;
  logic [SNW-1:0] w_remain;
  logic [SNW-1:0] w_next_pos;

  sensor_sync_filter #(.FILTER_LEN(C_FILTER_LEN)) u_zpd_sync (
    .clk(clk), .resetn(resetn), .i_raw(zpd), .o_sign(w_zpsign)
  );

  sensor_sync_filter #(.FILTER_LEN(C_FILTER_LEN)) u_tpd_sync (
    .clk(clk), .resetn(resetn), .i_raw(tpd), .o_sign(w_tpsign)
  );

  assign w_speed_clamp = (bus.speed < SDW'(MIN_SPEED)) ? SDW'(MIN_SPEED) : bus.speed;
  assign w_half        = r_period >> 1;
  assign w_low_len     = r_period - w_half;
  assign w_moving      = (r_fsm != ST_IDLE);

  // A start toward a sensor that is already asserted is refused; stop wins over start.
  assign w_blocked  = (bus.dir == DIR_POS) ? w_tpsign : w_zpsign;
  assign w_accept   = !w_moving && bus.sel && bus.start && !bus.stop &&
                      (bus.step != '0) && !w_blocked;
  assign w_zero_hit = (r_dir == DIR_NEG) && w_zpsign;
  assign w_term_hit = (r_dir == DIR_POS) && w_tpsign;
  assign w_abort    = w_moving && ((bus.sel && bus.stop) || w_zero_hit || w_term_hit);
  assign w_remain   = (bus.sel && bus.mod_remain) ? bus.new_remain : r_remain;
  assign w_next_pos = (r_dir == DIR_POS) ? r_position + SNW'(1) : r_position - SNW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fsm      <= ST_IDLE;
      r_period   <= '0;
      r_cnt      <= '0;
      r_remain   <= '0;
      r_position <= '0;
      r_dir      <= 1'b0;
      r_drive    <= 1'b0;
    end else if (w_abort) begin
      r_fsm    <= ST_IDLE;
      r_cnt    <= '0;
      r_remain <= '0;
      r_drive  <= 1'b0;
      if (w_zero_hit) begin
        r_position <= '0;
      end
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_fsm      <= ST_HIGH;
            r_period   <= w_speed_clamp;
            r_dir      <= bus.dir;
            r_cnt      <= '0;
            r_remain   <= bus.step - SNW'(1);
            r_drive    <= 1'b1;
            r_position <= (bus.dir == DIR_POS) ? r_position + SNW'(1)
                                               : r_position - SNW'(1);
          end
        end
        ST_HIGH: begin
          r_remain <= w_remain;
          if (r_cnt == w_half - SDW'(1)) begin
            r_fsm   <= ST_LOW;
            r_cnt   <= '0;
            r_drive <= 1'b0;
          end else begin
            r_cnt <= r_cnt + SDW'(1);
          end
        end
        ST_LOW: begin
          if (r_cnt != w_low_len - SDW'(1)) begin
            r_cnt    <= r_cnt + SDW'(1);
            r_remain <= w_remain;
          end else if (w_remain != '0) begin
            r_fsm      <= ST_HIGH;
            r_cnt      <= '0;
            r_remain   <= w_remain - SNW'(1);
            r_drive    <= 1'b1;
            r_position <= w_next_pos;
          end else begin
            r_fsm    <= ST_IDLE;
            r_cnt    <= '0;
            r_remain <= '0;
          end
        end
        default: begin
          r_fsm   <= ST_IDLE;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state    = w_moving;
  assign bus.position = r_position;
  assign bus.zpsign   = w_zpsign;
  assign bus.tpsign   = w_tpsign;
  assign o_drive      = r_drive;
  assign o_dir        = r_dir;
  assign o_xen        = w_moving;

endmodule

`default_nettype wire

// File: tb/tb_motor_step_gen.sv
// ============================================================================
//  Module      : tb_motor_step_gen
//  Description : Randomised self-checking bench for motor_step_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_step_gen;

  localparam int SDW  = 32;
  localparam int SNW  = 8;
  localparam int FLEN = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic zpd = 1'b0;
  logic tpd = 1'b0;
  logic o_drive, o_dir, o_xen;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a move is a number of periods, each indexed 0..P-1.
  bit          m_moving, m_dir, m_zs, m_ts;
  int          m_P, m_t, m_left, m_pos;
  logic [63:0] zh, th;

  always #5 clk = ~clk;

  motor_step_gen_if #(.SDW(SDW), .SNW(SNW)) bus ();

  motor_step_gen #(
    .C_SPEED_DATA_WIDTH(SDW), .C_STEP_NUMBER_WIDTH(SNW), .C_FILTER_LEN(FLEN)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave), .zpd(zpd), .tpd(tpd),
    .o_drive(o_drive), .o_dir(o_dir), .o_xen(o_xen)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronised level after this edge; h[j] is the raw level sampled j edges ago.
  function automatic bit sens_next(input bit cur, input logic [63:0] h);
`ifdef MSG_SENSOR_FILTER_EN
    for (int i = 2; i <= FLEN + 1; i++) begin
      if (h[i] == cur) return cur;
    end
    return ~cur;
`else
    return h[1];
`endif
  endfunction

  task automatic model_reset();
    m_moving = 0; m_dir = 0; m_zs = 0; m_ts = 0;
    m_P = 2; m_t = 0; m_left = 0; m_pos = 0;
    zh = '0; th = '0;
  endtask

  task automatic model_edge();
    bit zs_old, ts_old, zero_hit, term_hit;
    if (!resetn) begin
      model_reset();
      return;
    end
    zs_old = m_zs;
    ts_old = m_ts;
    zh = {zh[62:0], zpd};
    th = {th[62:0], tpd};
    m_zs = sens_next(m_zs, zh);
    m_ts = sens_next(m_ts, th);
    if (!m_moving) begin
      if (bus.sel && bus.start && !bus.stop && bus.step != 0 &&
          !(bus.dir ? ts_old : zs_old)) begin
        m_moving = 1;
        m_P      = (bus.speed < 2) ? 2 : int'(bus.speed);
        m_t      = 0;
        m_left   = int'(bus.step) - 1;
        m_dir    = bus.dir;
        m_pos    = (m_pos + (m_dir ? 1 : 255)) & 255;
      end
    end else begin
      zero_hit = !m_dir && zs_old;
      term_hit = m_dir && ts_old;
      if ((bus.sel && bus.stop) || zero_hit || term_hit) begin
        m_moving = 0;
        if (zero_hit) m_pos = 0;
      end else begin
        if (bus.sel && bus.mod_remain) m_left = int'(bus.new_remain);
        if (m_t == m_P - 1) begin
          if (m_left != 0) begin
            m_left--;
            m_t   = 0;
            m_pos = (m_pos + (m_dir ? 1 : 255)) & 255;
          end else begin
            m_moving = 0;
          end
        end else begin
          m_t++;
        end
      end
    end
  endtask

  task automatic compare();
    check("state",  bus.state,    m_moving);
    check("xen",    o_xen,        m_moving);
    check("drive",  o_drive,      m_moving && (m_t < m_P / 2));
    check("pos",    bus.position, m_pos);
    check("dir",    o_dir,        m_dir);
    check("zpsign", bus.zpsign,   m_zs);
    check("tpsign", bus.tpsign,   m_ts);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (m_moving && n < max) begin
      cycle();
      n++;
    end
    if (m_moving) check("idle_timeout", 1, 0);
    cycle();
  endtask

  task automatic do_start(input int sp, input int st, input bit d, input bit stp);
    bus.speed = SDW'(sp);
    bus.step  = SNW'(st);
    bus.dir   = d;
    bus.start = 1'b1;
    bus.stop  = stp;
    cycle();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic pulse_mod(input int nr);
    bus.mod_remain = 1'b1;
    bus.new_remain = SNW'(nr);
    cycle();
    bus.mod_remain = 1'b0;
  endtask

  initial begin
    bus.sel = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.speed = '0;
    bus.step = '0; bus.dir = 1'b0; bus.mod_remain = 1'b0; bus.new_remain = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    resetn = 1'b1;
    run(3);

    // Three steps, period 10
    do_start(10, 3, 1'b1, 1'b0);
    check("t1_rise", o_drive, 1);
    run_idle(100);
    check("t1_pos", bus.position, 3);

    // Period clamped to 2
    do_start(1, 2, 1'b1, 1'b0);
    run_idle(20);
    check("t2_pos_a", bus.position, 5);
    do_start(0, 2, 1'b1, 1'b0);
    run_idle(20);
    check("t2_pos_b", bus.position, 7);

    // Zero sensor during a negative move
    do_start(8, 10, 1'b0, 1'b0);
    run(20);
    zpd = 1'b1;
    run(3);
    check("t3_abort_state", bus.state, 0);
    check("t3_abort_pos", bus.position, 0);
    do_start(8, 10, 1'b0, 1'b0);
    check("t3_reject", bus.state, 0);
    run(2);
    zpd = 1'b0;
    run(4);

    // Stop after two steps, then start+stop together
    do_start(4, 5, 1'b1, 1'b0);
    run(5);
    pulse_stop();
    check("t4_stop_state", bus.state, 0);
    check("t4_stop_pos", bus.position, 2);
    do_start(4, 5, 1'b1, 1'b1);
    check("t4_start_stop", bus.state, 0);
    run(2);

    // Remaining-count overwrite
    do_start(6, 4, 1'b1, 1'b0);
    pulse_mod(0);
    run_idle(50);
    check("t5_one_step", bus.position, 3);
    do_start(6, 4, 1'b1, 1'b0);
    pulse_mod(7);
    run_idle(100);
    check("t5_eight_steps", bus.position, 11);
    pulse_mod(3);
    check("t5_idle_mod", bus.state, 0);

    // Terminal sensor glitch and longer pulse
    tpd = 1'b1; cycle(); tpd = 1'b0;
    run(FLEN + 4);
    tpd = 1'b1; run(6); tpd = 1'b0;
    run(FLEN + 4);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.sel = ($urandom_range(0, 9) != 0);
      if (r < 40) begin
        bus.speed = SDW'($urandom_range(0, 9));
        bus.step  = SNW'($urandom_range(0, 6));
        bus.dir   = 1'($urandom_range(0, 1));
        bus.start = 1'b1;
        bus.stop  = ($urandom_range(0, 9) == 0);
      end else if (r < 50) begin
        bus.stop = 1'b1;
      end else if (r < 65) begin
        bus.mod_remain = 1'b1;
        bus.new_remain = SNW'($urandom_range(0, 4));
      end else if (r < 72) begin
        zpd = ~zpd;
      end else if (r < 79) begin
        tpd = ~tpd;
      end
      cycle();
      bus.start = 1'b0; bus.stop = 1'b0; bus.mod_remain = 1'b0;
      run($urandom_range(0, 6));
    end

    // Asynchronous reset during a move
    bus.sel = 1'b1; zpd = 1'b0; tpd = 1'b0;
    run(FLEN + 4);
    do_start(6, 5, 1'b1, 1'b0);
    run(8);
    resetn = 1'b0;
    #1;
    check("rst_state", bus.state, 0);
    check("rst_drive", o_drive, 0);
    check("rst_xen", o_xen, 0);
    check("rst_dir", o_dir, 0);
    check("rst_pos", bus.position, 0);
    model_reset();
    cycle();
    resetn = 1'b1;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
